// File: rtl/rsc_decoder_if.sv
`default_nettype none
// ============================================================================
// Module      : rsc_decoder_if
// Description : Stream bundle for rsc_decoder. The master drives the received
//               systematic/parity pairs and the start pulse; the slave (the
//               decoder) returns the recovered bits and frame status.
// Ports       : data_ready, K, xk, zk            master -> slave
//               ck, ck_valid, busy, done,
//               err_cnt[CNT_W], frame_ok, state[3] slave -> master
// Revision    : 1.0  initial release
// ============================================================================
interface rsc_decoder_if #(
  parameter int CNT_W = 13
);
  logic             data_ready;
  logic             K;
  logic             xk;
  logic             zk;
  logic             ck;
  logic             ck_valid;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] err_cnt;
  logic             frame_ok;
  logic [2:0]       state;

  modport master (
    output data_ready, K, xk, zk,
    input  ck, ck_valid, busy, done, err_cnt, frame_ok, state
  );

  modport slave (
    input  data_ready, K, xk, zk,
    output ck, ck_valid, busy, done, err_cnt, frame_ok, state
  );
endinterface
`default_nettype wire

// File: rtl/rsc_decoder.sv
`default_nettype none
// ============================================================================
// Module      : rsc_decoder
// Description : Hard-decision checker for the 8-state LTE constituent RSC code
//               (g0=13, g1=15 octal, 3-pair trellis termination). Re-runs the
//               encoder trellis on the received systematic stream, forwards
//               the systematic bits as recovered information bits and counts
//               parity mismatches per block.
// Ports       : clk        rising-edge clock
//               aclr_n     asynchronous active-low reset
//               bus        rsc_decoder_if.slave (pairs in, bits/status out)
// Config      : RSC_DEC_TAIL_CHECK_EN - when defined, the 3 tail pairs are
//               checked and contribute to err_cnt; frame_ok also requires the
//               tracked state to terminate at zero.
// Revision    : 1.0  initial release
// ============================================================================
module rsc_decoder #(
  parameter int K_SMALL = 1056,
  parameter int K_LARGE = 6144,
  parameter int CNT_W   = 13
) (
  input  wire logic    clk,
  input  wire logic    aclr_n,
  rsc_decoder_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    TAIL = 2'd2,
    DONE = 2'd3
  } fsm_t;

  localparam logic [CNT_W-1:0] C_K_SMALL = CNT_W'(K_SMALL);
  localparam logic [CNT_W-1:0] C_K_LARGE = CNT_W'(K_LARGE);
  localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_TAIL    = CNT_W'(3);

  fsm_t             r_fsm;
  logic             r_ksel;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_err_cnt;
  logic [2:0]       r_state;
  logic             r_ck;
  logic             r_ck_valid;
  logic             r_busy;
  logic             r_done;
  logic             r_frame_ok;

  logic [CNT_W-1:0] w_klen;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_fb;
  logic             w_s;
  logic             w_data_err;
  logic             w_p_tail;
  logic             w_tail_err;
  logic             w_tail_state_ok;
  logic [CNT_W-1:0] w_err_data_next;
  logic [CNT_W-1:0] w_err_tail_next;

  assign w_klen     = r_ksel ? C_K_LARGE : C_K_SMALL;
  assign w_cnt_next = r_cnt + C_ONE;

  // Trellis: state {q2,q1,q0}; feedback taps q1,q2 (g0), parity taps s,q0,q2 (g1).
  assign w_fb       = r_state[1] ^ r_state[2];
  assign w_s        = bus.xk ^ w_fb;
  assign w_data_err = bus.zk ^ (w_s ^ r_state[0] ^ r_state[2]);
  assign w_p_tail   = r_state[0] ^ r_state[2];

`ifdef RSC_DEC_TAIL_CHECK_EN
  // During termination the transmitted systematic bit equals the feedback,
  // so a clean tail drives the register to zero.
  assign w_tail_err      = (bus.xk ^ w_fb) | (bus.zk ^ w_p_tail);
  // State after this final shift is {q1,q0,0}.
  assign w_tail_state_ok = (r_state[1:0] == 2'b00);
`else
  assign w_tail_err      = 1'b0;
  assign w_tail_state_ok = 1'b1;
`endif

  assign w_err_data_next = r_err_cnt + {{(CNT_W-1){1'b0}}, w_data_err};
  assign w_err_tail_next = r_err_cnt + {{(CNT_W-1){1'b0}}, w_tail_err};

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      r_fsm      <= IDLE;
      r_ksel     <= 1'b0;
      r_cnt      <= '0;
      r_err_cnt  <= '0;
      r_state    <= 3'b000;
      r_ck       <= 1'b0;
      r_ck_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_frame_ok <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (bus.data_ready) begin
        // Start (or restart from any state): pair 0 is processed from the
        // all-zero state, where s = xk and expected parity = xk.
        r_fsm      <= DATA;
        r_ksel     <= bus.K;
        r_cnt      <= C_ONE;
        r_state    <= {2'b00, bus.xk};
        r_err_cnt  <= {{(CNT_W-1){1'b0}}, bus.xk ^ bus.zk};
        r_ck       <= bus.xk;
        r_ck_valid <= 1'b1;
        r_busy     <= 1'b1;
      end else begin
        case (r_fsm)
          IDLE: begin
            r_ck_valid <= 1'b0;
          end
          DATA: begin
            r_state    <= {r_state[1:0], w_s};
            r_err_cnt  <= w_err_data_next;
            r_ck       <= bus.xk;
            r_ck_valid <= 1'b1;
            r_cnt      <= w_cnt_next;
            if (w_cnt_next == w_klen) begin
              r_fsm <= TAIL;
            end
          end
          TAIL: begin
            r_state    <= {r_state[1:0], 1'b0};
            r_err_cnt  <= w_err_tail_next;
            r_ck_valid <= 1'b0;
            r_cnt      <= w_cnt_next;
            if (w_cnt_next == (w_klen + C_TAIL)) begin
              r_fsm      <= DONE;
              r_done     <= 1'b1;
              r_frame_ok <= (w_err_tail_next == '0) && w_tail_state_ok;
            end
          end
          DONE: begin
            r_fsm      <= IDLE;
            r_busy     <= 1'b0;
            r_ck_valid <= 1'b0;
          end
          default: begin
            r_fsm <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.ck       = r_ck;
  assign bus.ck_valid = r_ck_valid;
  // The start cycle is flagged busy before the first registered update.
  assign bus.busy     = r_busy | bus.data_ready;
  assign bus.done     = r_done;
  assign bus.err_cnt  = r_err_cnt;
  assign bus.frame_ok = r_frame_ok;
  assign bus.state    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_rsc_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_rsc_decoder
// Description : Self-checking bench for rsc_decoder. A reference LTE RSC
//               encoder generates pairs; expected bits and frame results are
//               queued at drive time and compared as the decoder emits them.
//               Expectations for tail handling follow RSC_DEC_TAIL_CHECK_EN.
// Revision    : 1.0  initial release
// ============================================================================
module tb_rsc_decoder;

  localparam int CNT_W   = 13;
  localparam int K_SMALL = 1056;
  localparam int K_LARGE = 6144;

  typedef struct {
    int       err;
    bit       ok;
    bit [2:0] st;
    int       done_cyc;
  } frame_res_t;

  logic clk    = 1'b0;
  logic aclr_n = 1'b0;
  int   cyc    = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  bit         ck_q[$];
  frame_res_t res_q[$];
  bit         mon_bit;
  frame_res_t mon_res;

  rsc_decoder_if #(.CNT_W(CNT_W)) bus();

  rsc_decoder #(
    .K_SMALL(K_SMALL),
    .K_LARGE(K_LARGE),
    .CNT_W  (CNT_W)
  ) dut (
    .clk   (clk),
    .aclr_n(aclr_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] out_vec();
    return 32'({bus.ck, bus.ck_valid, bus.busy, bus.done, bus.err_cnt, bus.frame_ok, bus.state});
  endfunction

  task automatic drive(input bit dr, input bit k, input bit x, input bit z);
    @(negedge clk);
    bus.data_ready = dr;
    bus.K          = k;
    bus.xk         = x;
    bus.zk         = z;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // tq: transmitter encoder on true data; rq: receiver-side expectation
  // tracked on the received systematic stream.
  task automatic run_frame(input bit ksel, input bit zero_data, input bit force_x0,
                           input int flip_a, input int flip_b, input bit bad_tail,
                           input int stop_at);
    int         klen;
    bit [2:0]   tq;
    bit [2:0]   rq;
    int         err;
    int         start;
    bit         u, x, z, s;
    frame_res_t r;
    klen  = ksel ? K_LARGE : K_SMALL;
    tq    = 3'b000;
    rq    = 3'b000;
    err   = 0;
    start = 0;
    for (int i = 0; i < klen; i++) begin
      u  = zero_data ? 1'b0 : 1'($urandom);
      s  = u ^ tq[1] ^ tq[2];
      z  = s ^ tq[0] ^ tq[2];
      tq = {tq[1:0], s};
      x  = u;
      if (force_x0 && i == 0) x = 1'b1;
      if (i == flip_a || i == flip_b) z = ~z;
      s = x ^ rq[1] ^ rq[2];
      if (z != (s ^ rq[0] ^ rq[2])) err++;
      rq = {rq[1:0], s};
      drive(i == 0, ksel, x, z);
      ck_q.push_back(x);
      if (i == 0) begin
        start = cyc;
        #1;
        check_value("busy_cycle0", bus.busy, 1);
      end
      if (stop_at == i + 1) return;
    end
    for (int j = 0; j < 3; j++) begin
      x  = tq[1] ^ tq[2];
      z  = tq[0] ^ tq[2];
      tq = {tq[1:0], 1'b0};
      if (bad_tail) z = ~z;
`ifdef RSC_DEC_TAIL_CHECK_EN
      if ((x != (rq[1] ^ rq[2])) || (z != (rq[0] ^ rq[2]))) err++;
`endif
      rq = {rq[1:0], 1'b0};
      drive(1'b0, ksel, x, z);
    end
    r.err = err;
    r.st  = rq;
`ifdef RSC_DEC_TAIL_CHECK_EN
    r.ok  = (err == 0) && (rq == 3'b000);
`else
    r.ok  = (err == 0);
`endif
    r.done_cyc = start + klen + 3;
    res_q.push_back(r);
  endtask

  // Output monitor: samples 1 time unit after each rising edge.
  always begin
    @(posedge clk);
    #1;
    if (bus.ck_valid === 1'b1) begin
      check_value("ck_expected", 32'(ck_q.size() != 0), 1);
      if (ck_q.size() != 0) begin
        mon_bit = ck_q.pop_front();
        check_value("ck", bus.ck, mon_bit);
      end
    end
    if (bus.done === 1'b1) begin
      check_value("done_expected", 32'(res_q.size() != 0), 1);
      if (res_q.size() != 0) begin
        mon_res = res_q.pop_front();
        check_value("err_cnt", bus.err_cnt, mon_res.err);
        check_value("frame_ok", bus.frame_ok, mon_res.ok);
        check_value("state", bus.state, mon_res.st);
        check_value("done_cycle", cyc, mon_res.done_cyc);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.data_ready = 1'b0;
    bus.K          = 1'b0;
    bus.xk         = 1'b0;
    bus.zk         = 1'b0;
    aclr_n         = 1'b0;

    // Reset and quiet idle period
    repeat (3) @(negedge clk);
    #2 check_value("reset_outputs", out_vec(), 0);
    @(negedge clk);
    aclr_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #2 check_value("idle_outputs", out_vec(), 0);
    end

    // Clean K=0 frame
    run_frame(1'b0, 1'b0, 1'b0, -1, -1, 1'b0, -1);
    idle(5);
    check_value("busy_after_frame", bus.busy, 0);

    // Parity errors at bits 100 and 4000, K=1
    run_frame(1'b1, 1'b0, 1'b0, 100, 4000, 1'b0, -1);
    idle(5);

    // Systematic error: zero data, xk forced to 1 at bit 0
    run_frame(1'b0, 1'b1, 1'b1, -1, -1, 1'b0, -1);
    idle(5);

    // Restart at bit 500 of an errored frame; only the clean restart counts
    run_frame(1'b0, 1'b0, 1'b0, 10, 20, 1'b0, 500);
    run_frame(1'b0, 1'b0, 1'b0, -1, -1, 1'b0, -1);
    idle(5);

    // Asynchronous clear at bit 300, then a clean frame
    run_frame(1'b0, 1'b0, 1'b0, -1, -1, 1'b0, 300);
    @(negedge clk);
    aclr_n         = 1'b0;
    bus.data_ready = 1'b0;
    #1;
    check_value("aclr_outputs", out_vec(), 0);
    check_value("ck_q_drained", ck_q.size(), 0);
    repeat (2) @(negedge clk);
    aclr_n = 1'b1;
    idle(3);
    run_frame(1'b0, 1'b0, 1'b0, -1, -1, 1'b0, -1);
    idle(5);

    // Corrupted tail parity, followed back-to-back by a clean frame
    run_frame(1'b0, 1'b0, 1'b0, -1, -1, 1'b1, -1);
    run_frame(1'b0, 1'b0, 1'b0, -1, -1, 1'b0, -1);

    for (int t = 0; t < 20 && res_q.size() != 0; t++) idle(1);
    check_value("all_frames_done", res_q.size(), 0);
    check_value("all_bits_seen", ck_q.size(), 0);
    idle(2);
    check_value("final_busy", bus.busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rsc_decoder.md
# rsc_decoder

Hard-decision receive-side counterpart of the 8-state LTE constituent RSC encoder (g0=13, g1=15 octal, 3-bit trellis termination). It consumes received systematic/parity bit pairs for one K-bit block plus 3 tail pairs. It re-runs the encoder trellis from the systematic stream and delivers the information bits, together with a per-block parity mismatch count and a termination check. It sits between the channel de-mapper and the block sink, and gives a cheap integrity check before or without full iterative decoding.

## Interface
- K_SMALL, 1056, block length when K=0
- K_LARGE, 6144, block length when K=1
- CNT_W, 13, width of the bit counter and err_cnt; must hold K_LARGE+3
- clk  in  1  rising-edge clock
- aclr_n  in  1  asynchronous active-low reset
- data_ready  in  1  one-cycle start pulse; the first bit pair is valid in the same cycle
- K  in  1  block size select, sampled only when data_ready=1
- xk  in  1  received systematic bit
- zk  in  1  received parity bit
- ck  out  1  recovered information bit, registered
- ck_valid  out  1  ck qualifier
- busy  out  1  frame in progress, including data and tail phases
- done  out  1  one-cycle pulse at end of frame
- err_cnt  out  CNT_W  mismatches in the last or current frame
- frame_ok  out  1  last completed frame clean
- state  out  3  tracked encoder state {q2,q1,q0}

## Operation
- FSM states: IDLE, DATA, TAIL, DONE.
  - IDLE→DATA on data_ready.
  - DATA→TAIL after K pairs.
  - TAIL→DONE after 3 pairs.
  - DONE→IDLE after 1 cycle, or →DATA if data_ready.
- The bit counter is 1 at the data_ready cycle. Block size Ksel is latched at data_ready.
- Trellis update for DATA pair i:
  - s = xk^q1^q2
  - expected parity p = s^q0^q2
  - next state: q0←s, q1←q0, q2←q1
  - ck←xk
  - zk≠p increments err_cnt
- Trellis update for TAIL pairs:
  - feedback f = q1^q2, so s = 0
  - expected parity p = q0^q2
  - expected systematic = f
  - state shifts in 0
  - each cycle with any mismatch increments err_cnt by 1
  - ck_valid stays 0
- frame_ok is updated at DONE: err_cnt==0 and state==0.
- err_cnt cannot exceed K_LARGE+3; no saturation logic is required.
- data_ready while busy or in DONE aborts the current frame and restarts:
  - state, counter and err_cnt are cleared, then that cycle's pair is processed as bit 0.
  - No done pulse is generated for the aborted frame.
  - frame_ok keeps its previous value.
- xk/zk are ignored in IDLE.

## Timing
- Reset, asynchronous: all outputs 0 (ck, ck_valid, busy, done, err_cnt, frame_ok, state); FSM→IDLE.
- Cycle numbering: cycle 0 is the data_ready cycle. Pair n is sampled at the edge ending cycle n.
- ck_valid=1 in cycles 1..K, with ck equal to the xk of cycle n-1. Latency is 1 cycle.
- busy=1 in cycles 1..K+3. Combinationally, busy also covers cycle 0 via data_ready.
- done=1 in cycle K+3 only. err_cnt and frame_ok are final in that cycle and held until the next data_ready.
- err_cnt clears at the edge ending cycle 0. The cycle-0 mismatch is counted in that same update.
- If aclr_n is asserted mid-frame, outputs clear immediately and no done is produced. The next data_ready starts normally.
- Back-to-back frames: data_ready in cycle K+3 is legal, with zero gap.

## Configuration
- RSC_DEC_TAIL_CHECK_EN defined:
  - tail systematic and parity pairs are compared;
  - frame_ok requires err_cnt==0 and state==0.
- RSC_DEC_TAIL_CHECK_EN undefined:
  - tail pairs are consumed, with identical timing, but never counted;
  - frame_ok = (err_cnt==0);
  - the state output still reflects the tail shifts.

## Test plan
- Reset: hold aclr_n=0 for 3 cycles, then release with idle inputs → all outputs 0, busy=0 for 10 cycles.
- Clean frame, K=0: 1056 random bits plus tail from the reference encoder model → 1056 ck_valid pulses matching the source bits, done at cycle 1059, err_cnt=0, frame_ok=1, state=0.
- Parity error, K=1: flip zk at bits 100 and 4000 → ck stream still correct, err_cnt=2, frame_ok=0.
- Systematic error, K=0: all-zero data with xk forced to 1 at bit 0 and zk all-zero → ck=1 at the first ck_valid, err_cnt>0, frame_ok=0.
- Restart and reset:
  - data_ready pulses again at bit 500 of a K=0 frame → exactly one done, 1059 cycles after the second pulse, with err_cnt counting only the second frame.
  - aclr_n=0 at bit 300 → no done; a following clean frame yields frame_ok=1.
- Macro check: corrupt all 3 tail zk bits of a clean K=0 frame → with RSC_DEC_TAIL_CHECK_EN, err_cnt=3 and frame_ok=0; without it, err_cnt=0 and frame_ok=1.
